// File: rtl/pcsrc_ctrl.sv
// pcsrc_ctrl: next-PC select and hazard control for branch, jal and two-cycle jalr redirects; PCSRC_PERF_EN adds redirect/stall counters
module pcsrc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       validE,
  input  logic       branchE,
  input  logic       jumpE,
  input  logic       jalrE,
  input  logic [2:0] funct3E,
  input  logic       zeroE,
  input  logic       ltE,
  input  logic       ltuE,
  output logic [1:0] pcsrcE,
  output logic       stallF,
  output logic       flushD,
  output logic       flushE,
  output logic       busy
`ifdef PCSRC_PERF_EN
  ,
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_M, WAIT_W} state_t;
  state_t r_state, w_st, w_next;
  logic   w_cond, w_taken, w_redir;
  // Branch condition: bit 0 inverts the base compare, 010/011 never taken
  always_comb begin
    w_cond  = funct3E[2] ? ((funct3E[1] ? ltuE : ltE) ^ funct3E[0]) : (~funct3E[1] & (zeroE ^ funct3E[0]));
    w_taken = validE & branchE & w_cond;
    w_st    = rst ? IDLE : r_state;
  end
  // Output and next-state decode; reset forces the IDLE view of the inputs
  always_comb begin
    pcsrcE  = 2'b00;
    stallF  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    busy    = 1'b0;
    w_redir = 1'b0;
    w_next  = IDLE;
    if (w_st == WAIT_M) begin
      stallF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      busy   = 1'b1;
      w_next = WAIT_W;
    end else if (w_st == WAIT_W) begin
      pcsrcE  = 2'b10;
      flushD  = 1'b1;
      flushE  = 1'b1;
      busy    = 1'b1;
      w_redir = 1'b1;
    end else if (validE & jalrE) begin
      stallF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      busy   = 1'b1;
      w_next = WAIT_M;
    end else if (validE & jumpE) begin
      pcsrcE  = 2'b01;
      flushD  = 1'b1;
      flushE  = 1'b1;
      w_redir = 1'b1;
    end else if (w_taken) begin
      pcsrcE  = 2'b11;
      flushD  = 1'b1;
      flushE  = 1'b1;
      w_redir = 1'b1;
    end
  end
  // State register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
`ifdef PCSRC_PERF_EN
  // Saturating redirect and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (w_redir && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
      if (stallF && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pcsrc_ctrl.sv
// tb_pcsrc_ctrl: randomized and directed checks against a countdown-based reference model
module tb_pcsrc_ctrl;
  logic clk = 0, rst = 1, validE = 0, branchE = 0, jumpE = 0, jalrE = 0, zeroE = 0, ltE = 0, ltuE = 0;
  logic [2:0] funct3E = 0;
  logic [1:0] pcsrcE;
  logic stallF, flushD, flushE, busy;
  int passed = 0, total = 0;
  int pend = 0;
  int m_redir = 0, m_stall = 0;
`ifdef PCSRC_PERF_EN
  logic [15:0] redirect_cnt, stall_cnt;
`endif
  always #5 clk = ~clk;
  pcsrc_ctrl dut (
    .clk(clk), .rst(rst), .validE(validE), .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE),
    .funct3E(funct3E), .zeroE(zeroE), .ltE(ltE), .ltuE(ltuE),
    .pcsrcE(pcsrcE), .stallF(stallF), .flushD(flushD), .flushE(flushE), .busy(busy)
`ifdef PCSRC_PERF_EN
    , .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
`endif
  );
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic bit cond_of(input logic [2:0] f, input logic z, input logic l, input logic lu);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      3'd7: return !lu;
      default: return 0;
    endcase
  endfunction
  task automatic step(input logic r, input logic v, input logic b, input logic j, input logic jr,
                      input logic [2:0] f, input logic z, input logic l, input logic lu, input bit chk_out);
    int ep, es, efd, efe, eb, eredir;
    rst = r; validE = v; branchE = b; jumpE = j; jalrE = jr; funct3E = f; zeroE = z; ltE = l; ltuE = lu;
    @(negedge clk);
    ep = 0; es = 0; efd = 0; efe = 0; eb = 0; eredir = 0;
    if (!r && pend == 2) begin es = 1; efd = 1; efe = 1; eb = 1; end
    else if (!r && pend == 1) begin ep = 2; efd = 1; efe = 1; eb = 1; eredir = 1; end
    else if (v && jr) begin es = 1; efd = 1; efe = 1; eb = 1; end
    else if (v && j) begin ep = 1; efd = 1; efe = 1; eredir = 1; end
    else if (v && b && cond_of(f, z, l, lu)) begin ep = 3; efd = 1; efe = 1; eredir = 1; end
    if (chk_out) begin
      check("pcsrcE", pcsrcE, ep);
      check("stallF", stallF, es);
      check("flushD", flushD, efd);
      check("flushE", flushE, efe);
      check("busy", busy, eb);
    end
    @(posedge clk);
    if (r) begin pend = 0; m_redir = 0; m_stall = 0; end
    else begin
      if (eredir && m_redir < 65535) m_redir++;
      if (es == 1 && m_stall < 65535) m_stall++;
      if (pend > 0) pend--;
      else if (v && jr) pend = 2;
    end
    #1;
  endtask
  task automatic check_cnt(input string tag);
`ifdef PCSRC_PERF_EN
    check({tag, "_redirect_cnt"}, redirect_cnt, m_redir);
    check({tag, "_stall_cnt"}, stall_cnt, m_stall);
`endif
  endtask
  initial begin
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_cnt("reset");
    step(0, 1, 1, 0, 0, 3'd0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 3'd0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 3'd5, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 3'd2, 1, 1, 1, 1);
    step(0, 1, 1, 0, 0, 3'd3, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 1, 3'd0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1, 3'd0, 1, 1, 1, 1);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 1, 3'd0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1, 3'd0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 3'd0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_cnt("mix");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
    check_cnt("random");
`ifdef PCSRC_PERF_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    check_cnt("saturate");
    check("saturate_value", redirect_cnt, 65535);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pcsrc_ctrl.md
PCSRC_CTRL -- requirements
Module: pcsrc_ctrl

Interface
REQ-001 Parameter: none; all widths fixed below.
REQ-002 The block SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 validE input 1: E-stage holds a real instruction, not a bubble.
REQ-004 branchE input 1: E instruction is a conditional branch.
REQ-005 jumpE input 1: E instruction is jal.
REQ-006 jalrE input 1: E instruction is jalr.
REQ-007 funct3E input 3: branch condition code.
REQ-008 zeroE, ltE, ltuE inputs 1 each: ALU equal, signed-less, unsigned-less flags for E operands.
REQ-009 pcsrcE output 2: next-PC select. 00 = pc+4, 01 = jal target, 10 = jalr target from W, 11 = branch target.
REQ-010 stallF output 1: hold the PC register.
REQ-011 flushD output 1: clear the D pipeline register at the next edge.
REQ-012 flushE output 1: clear the E pipeline register at the next edge.
REQ-013 busy output 1: jalr resolution is in progress.

Function
REQ-014 Branch decode SHALL follow this table, with taken = validE & branchE & cond:
- 000 BEQ = zeroE
- 001 BNE = ~zeroE
- 100 BLT = ltE
- 101 BGE = ~ltE
- 110 BLTU = ltuE
- 111 BGEU = ~ltuE
- 010 and 011 SHALL be not taken.
REQ-015 The FSM SHALL have three states: IDLE, WAIT_M and WAIT_W, with registered state and combinational outputs.
REQ-016 In IDLE with validE & jalrE, the block SHALL drive pcsrcE=00, stallF=1, flushD=1, flushE=1, busy=1, and go to WAIT_M.
REQ-017 In IDLE with validE & jumpE (no jalrE), the block SHALL drive pcsrcE=01, flushD=1, flushE=1, stallF=0, and stay in IDLE.
REQ-018 In IDLE with a taken branch (no jump/jalr), the block SHALL drive pcsrcE=11, flushD=1, flushE=1, stallF=0, and stay in IDLE.
REQ-019 In IDLE with no redirect, the block SHALL drive pcsrcE=00 with all control outputs 0.
REQ-020 Priority for simultaneous type flags SHALL be jalrE > jumpE > branchE.
REQ-021 In WAIT_M, the block SHALL drive pcsrcE=00, stallF=1, flushD=1, flushE=1, busy=1, and go to WAIT_W.
REQ-022 In WAIT_W, the block SHALL drive pcsrcE=10, stallF=0, flushD=1, flushE=1, busy=1, and go to IDLE.
REQ-023 Jalr redirect latency SHALL be exactly 2 cycles after the E cycle; the PC loads aluresultW at the end of the WAIT_W cycle.
REQ-024 In WAIT_M and WAIT_W, all E-stage inputs SHALL be ignored (E holds bubbles).
REQ-025 With validE=0, no redirect SHALL occur regardless of branch, jump or jalr flags.
REQ-026 Back-to-back: a jalr arriving in E in the cycle after WAIT_W SHALL be accepted normally from IDLE.

Reset
REQ-027 While rst=1 at a clock edge, the state SHALL become IDLE.
REQ-028 During reset, outputs SHALL follow IDLE decode with validE gating; counters (if present) SHALL clear to 0.
REQ-029 Reset asserted in WAIT_M or WAIT_W SHALL abandon the jalr and leave the block in IDLE next cycle with pcsrcE=00.

Configuration
REQ-030 Macro PCSRC_PERF_EN SHALL control performance counters.
REQ-031 With PCSRC_PERF_EN defined, the block SHALL add outputs redirect_cnt[15:0] and stall_cnt[15:0].
- redirect_cnt increments once per jal/branch/jalr redirect, with jalr counted in WAIT_W.
- stall_cnt increments every cycle stallF=1.
- Both SHALL saturate at 16'hFFFF.
- Both SHALL be synchronously cleared by rst.
REQ-032 Without PCSRC_PERF_EN, neither counter port nor counter logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-033 validE=1, branchE=1, funct3E=000, zeroE=1 -> same cycle pcsrcE=11, flushD=flushE=1, stallF=0; with zeroE=0 -> pcsrcE=00, flushes 0.
REQ-034 validE=1, branchE=1, funct3E=101, ltE=0 -> taken, pcsrcE=11; funct3E=010 with any flags -> not taken.
REQ-035 validE=1, jalrE=1 at cycle 0 -> cycle 0 pcsrcE=00, stallF=1; cycle 1 state WAIT_M, stallF=1; cycle 2 pcsrcE=10, stallF=0; cycle 3 IDLE, busy=0.
REQ-036 validE=1, jalrE=1, jumpE=1, branchE=1 simultaneously -> jalr sequence taken; with validE=0 and all flags 1 -> pcsrcE=00, no flush.
REQ-037 jalr accepted, rst=1 in WAIT_M -> next cycle IDLE, pcsrcE=00, busy=0, stallF=0.
REQ-038 With PCSRC_PERF_EN: one jal, one taken branch, one jalr -> redirect_cnt=3, stall_cnt=2; 70000 redirects -> redirect_cnt holds at 65535.
